// File: rtl/ofdm_bit_packer.sv
// Frame-aligned QPSK dibit packer: rebuilds 8-subcarrier symbols into 16-bit words behind a 2-entry buffer.
// Optional PACKER_PARITY_EN adds out_par, the even parity of out_word.
module ofdm_bit_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        in_x,
    input  logic        in_y,
    input  logic        in_sig,
    output logic [15:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sync_err,
    output logic        ovf,
    output logic        locked
`ifdef PACKER_PARITY_EN
    ,
    output logic        out_par
`endif
);

    localparam int NSUB  = 8;
    localparam int DEPTH = 2;
    localparam int W     = 2 * NSUB;

    typedef enum logic {HUNT, LOCK} state_t;

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [W-1:0]   acc_q, acc_d, acc_ins;
    logic [W-1:0]   buf_q [DEPTH];
    logic [W-1:0]   buf_d [DEPTH];
    logic [1:0]     cnt_q, cnt_d;
    logic [W-1:0]   word_q, word_d;
    logic           valid_q, valid_d;
    logic           sync_q, sync_d;
    logic           ovf_q, ovf_d;
    logic           push;
    logic           pop;
`ifdef PACKER_PARITY_EN
    logic           par_q, par_d;
`endif

    // acc with the current dibit dropped into its subcarrier lane; at idx 7 this is the finished word.
    genvar gi;
    generate
        for (gi = 0; gi < NSUB; gi++) begin : g_lane
            assign acc_ins[2*gi +: 2] = (idx_q == 3'(gi)) ? {in_x, in_y} : acc_q[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sync_d  = 1'b0;
        push    = 1'b0;
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (in_sig) begin
                        state_d = LOCK;
                        idx_d   = 3'd0;
                        acc_d   = '0;
                    end
                end
                LOCK: begin
                    if (idx_q == 3'd7) begin
                        if (in_sig) begin
                            push = 1'b1;
                        end else begin
                            sync_d  = 1'b1;
                            state_d = HUNT;
                        end
                        idx_d = 3'd0;
                        acc_d = '0;
                    end else if (in_sig) begin
                        // Early marker: drop the partial frame and restart on this boundary.
                        sync_d = 1'b1;
                        idx_d  = 3'd0;
                        acc_d  = '0;
                    end else begin
                        acc_d = acc_ins;
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Pop is applied before push so a full buffer can accept a word on a read edge.
    always_comb begin
        pop   = valid_q & out_ready;
        buf_d = buf_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                if (cnt_d == 2'd0) begin
                    buf_d[0] = acc_ins;
                end else begin
                    buf_d[1] = acc_ins;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
        valid_d = (cnt_d != 2'd0);
        word_d  = valid_d ? buf_d[0] : word_q;
`ifdef PACKER_PARITY_EN
        par_d   = ^word_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            idx_q   <= 3'd0;
            acc_q   <= '0;
            cnt_q   <= 2'd0;
            word_q  <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
`ifdef PACKER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
`ifdef PACKER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out_word  = word_q;
    assign out_valid = valid_q;
    assign sync_err  = sync_q;
    assign ovf       = ovf_q;
    assign locked    = (state_q == LOCK);
`ifdef PACKER_PARITY_EN
    assign out_par   = par_q;
`endif

endmodule

// File: tb/tb_ofdm_bit_packer.sv
// Bench for ofdm_bit_packer: queue-based frame/buffer model checked every cycle plus literal test-plan expectations.
module tb_ofdm_bit_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        in_x = 1'b0;
    logic        in_y = 1'b0;
    logic        in_sig = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_word;
    logic        out_valid;
    logic        sync_err;
    logic        ovf;
    logic        locked;
`ifdef PACKER_PARITY_EN
    logic        out_par;
`endif

    int checks = 0;
    int errors = 0;

    ofdm_bit_packer dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_sig    (in_sig),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sync_err  (sync_err),
        .ovf       (ovf),
        .locked    (locked)
`ifdef PACKER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of dibits collected since the last boundary, and a list of buffered words.
    bit          m_locked;
    logic [1:0]  m_dibits[$];
    logic [15:0] m_fifo[$];
    logic [15:0] m_word;
    bit          m_sync;
    bit          m_ovf;

    function automatic logic [15:0] pack_dibits(input logic [1:0] d[$]);
        logic [15:0] w = '0;
        for (int k = 0; k < d.size(); k++) begin
            w = w | (16'(d[k]) << (2 * k));
        end
        return w;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_dibits.delete();
        m_fifo.delete();
        m_word = '0;
        m_sync = 0;
        m_ovf = 0;
    endtask

    task automatic model_step();
        bit do_pop;
        bit do_push;
        logic [15:0] w;
        do_pop  = (m_fifo.size() > 0) && out_ready;
        do_push = 0;
        w = '0;
        m_sync = 0;
        if (en) begin
            if (!m_locked) begin
                if (in_sig) begin
                    m_locked = 1;
                    m_dibits.delete();
                end
            end else if (in_sig) begin
                if (m_dibits.size() == 7) begin
                    m_dibits.push_back({in_x, in_y});
                    w = pack_dibits(m_dibits);
                    do_push = 1;
                end else begin
                    m_sync = 1;
                end
                m_dibits.delete();
            end else if (m_dibits.size() == 7) begin
                m_sync = 1;
                m_locked = 0;
                m_dibits.delete();
            end else begin
                m_dibits.push_back({in_x, in_y});
            end
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (do_push) begin
            if (m_fifo.size() < 2) m_fifo.push_back(w);
            else m_ovf = 1;
        end
        if (m_fifo.size() > 0) m_word = m_fifo[0];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step();
            #1;
            check("out_valid", 16'(out_valid), 16'(m_fifo.size() > 0));
            check("out_word", out_word, m_word);
            check("sync_err", 16'(sync_err), 16'(m_sync));
            check("ovf", 16'(ovf), 16'(m_ovf));
            check("locked", 16'(locked), 16'(m_locked));
`ifdef PACKER_PARITY_EN
            check("out_par", 16'(out_par), 16'(^m_word));
`endif
            $display("cyc t=%0t en=%b x=%b y=%b sig=%b rdy=%b -> word=%h v=%b se=%b ovf=%b lk=%b",
                     $time, en, in_x, in_y, in_sig, out_ready, out_word, out_valid, sync_err, ovf, locked);
        end
    end

    // Inputs change on the falling edge; returns on the falling edge after the capture.
    task automatic dibit(input logic x, input logic y, input logic s);
        en = 1'b1; in_x = x; in_y = y; in_sig = s;
        @(negedge clk);
    endtask

    task automatic idle();
        en = 1'b0; in_x = 1'b0; in_y = 1'b0; in_sig = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int k = 0; k < 8; k++) begin
            dibit(w[2*k+1], w[2*k], k == 7);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", 16'(out_valid), 16'h0);
        check("reset_word", out_word, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        // Lock, then 8 dibits {1,0}.
        dibit(1'b0, 1'b0, 1'b1);
        send_word(16'hAAAA);
        check("t1_word", out_word, 16'hAAAA);
        check("t1_valid", 16'(out_valid), 16'h1);
        check("t1_locked", 16'(locked), 16'h1);
`ifdef PACKER_PARITY_EN
        check("t1_par", 16'(out_par), 16'h0);
`endif
        out_ready = 1'b1;
        idle();
        check("t1_drain", 16'(out_valid), 16'h0);

        // Subcarrier k carries k[1:0]; followed immediately by a second frame.
        send_word(16'hE4E4);
        check("t2_word", out_word, 16'hE4E4);
        check("t2_valid", 16'(out_valid), 16'h1);
        send_word(16'h0F0F);
        check("t2_b2b_word", out_word, 16'h0F0F);
        idle();
        check("t2_valid_drop", 16'(out_valid), 16'h0);
        check("t2_word_hold", out_word, 16'h0F0F);

        // Overflow with the consumer stalled.
        out_ready = 1'b0;
        send_word(16'h1111);
        send_word(16'h2222);
        check("t3_ovf_before", 16'(ovf), 16'h0);
        send_word(16'h3333);
        check("t3_ovf", 16'(ovf), 16'h1);
        check("t3_head", out_word, 16'h1111);
        out_ready = 1'b1;
        idle();
        check("t3_second", out_word, 16'h2222);
        check("t3_second_v", 16'(out_valid), 16'h1);
        idle();
        check("t3_empty", 16'(out_valid), 16'h0);
        check("t3_hold", out_word, 16'h2222);

        // Early marker on the 4th dibit.
        dibit(1'b1, 1'b1, 1'b0);
        dibit(1'b1, 1'b1, 1'b0);
        dibit(1'b1, 1'b1, 1'b0);
        dibit(1'b1, 1'b1, 1'b1);
        check("t4_sync", 16'(sync_err), 16'h1);
        check("t4_nopush", 16'(out_valid), 16'h0);
        idle();
        check("t4_sync_pulse", 16'(sync_err), 16'h0);
        send_word(16'h5A3C);
        check("t4_word", out_word, 16'h5A3C);

        // Missing marker on the 8th dibit drops lock.
        for (int k = 0; k < 8; k++) dibit(1'b1, 1'b0, 1'b0);
        check("t5_sync", 16'(sync_err), 16'h1);
        check("t5_unlocked", 16'(locked), 16'h0);
        send_word(16'h1234);
        check("t5_ignored", 16'(out_valid), 16'h0);
        check("t5_relocked", 16'(locked), 16'h1);
        send_word(16'hBEEF);
        check("t5_word", out_word, 16'hBEEF);
        idle();

        // Async reset mid-frame with a word buffered and ovf still set.
        out_ready = 1'b0;
        send_word(16'h7777);
        for (int k = 0; k < 5; k++) dibit(1'b0, 1'b1, 1'b0);
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_valid", 16'(out_valid), 16'h0);
        check("t6_ovf", 16'(ovf), 16'h0);
        check("t6_locked", 16'(locked), 16'h0);
        check("t6_word", out_word, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        dibit(1'b0, 1'b0, 1'b1);
        send_word(16'hC3A5);
        check("t6_after", out_word, 16'hC3A5);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofdm_bit_packer.md
# ofdm_bit_packer

Frame-aligned bit packer directly downstream of the QPSK demapper. Each cycle it takes one demapped dibit (x, y) and the demapper's frame marker, rebuilds the 8-subcarrier OFDM symbol as a 16-bit word, and hands the word to the MAC-side consumer through a 2-entry valid/ready buffer. Frame-alignment loss, word drops and (optionally) parity are reported alongside.

## Interface
- NSUB, 8: subcarriers per OFDM symbol; fixed at 8 (word width 2*NSUB = 16).
- DEPTH, 2: output buffer entries; fixed at 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  dibit on in_x/in_y/in_sig is valid this cycle.
- in_x  in  1  demapped dibit, sign-of-imag bit.
- in_y  in  1  demapped dibit, second bit.
- in_sig  in  1  high with the dibit of subcarrier 7 (last of frame).
- out_word  out  16  packed frame; bits [2k+1:2k] = {x,y} of subcarrier k.
- out_valid  out  1  out_word holds an unread word.
- out_ready  in  1  consumer accepts out_word when out_valid & out_ready.
- sync_err  out  1  one-cycle pulse on frame-alignment error.
- ovf  out  1  sticky: a completed word was dropped because the buffer was full.
- locked  out  1  high in state LOCK.

## Operation
- States: HUNT (reset state), LOCK. Subcarrier index idx[2:0], shift register acc[15:0].
- All actions below occur only on edges with en=1; en=0 holds all state (buffer pops still allowed).
- HUNT: dibits discarded. en & in_sig -> LOCK, idx<=0, acc cleared.
- LOCK, idx<7, in_sig=0: acc[2*idx+1:2*idx] <= {in_x,in_y}; idx<=idx+1.
- LOCK, idx==7, in_sig=1: word = acc with {in_x,in_y} in bits [15:14]; push word; idx<=0.
- LOCK, idx<7, in_sig=1: partial frame discarded, no push, sync_err pulse; idx<=0, stay LOCK (marker is treated as new boundary).
- LOCK, idx==7, in_sig=0: discard, sync_err pulse, go HUNT.
- Buffer: 2-entry FIFO, in-order. Push when full and no pop same edge -> word dropped, ovf<=1. Push and pop on same edge when full -> both happen, no drop.
- ovf cleared only by reset.
- Reset (any time, mid-frame included): state HUNT, idx=0, acc=0, buffer emptied, out_word=0, out_valid=0, sync_err=0, ovf=0, locked=0; partial frame lost.

## Timing
- Word pushed on the edge capturing the subcarrier-7 dibit; out_valid high from that edge (1-cycle latency from last dibit presented), no combinational bypass from inputs to outputs.
- out_word and out_valid registered; out_word holds head entry stable while out_valid & !out_ready.
- Pop on edge with out_valid & out_ready; next entry visible the same edge if present, else out_valid<=0, out_word holds last value.
- sync_err high exactly one cycle, the cycle after the offending edge.
- Back-to-back frames (8 en cycles each) sustain one word per 8 cycles with out_ready tied high.

## Configuration
- PACKER_PARITY_EN defined: extra output out_par (1 bit) = even parity (XOR) of out_word, registered with it; reset 0.
- Undefined: out_par port absent; all other behaviour identical.

## Test plan
- Reset, en=1, one in_sig pulse, then 8 dibits {1,0} with in_sig on 8th -> out_word=16'hAAAA, out_valid=1 one cycle after 8th dibit, locked=1; with PACKER_PARITY_EN out_par=0.
- Subcarrier k dibit = k[1:0] (k=0..7) -> out_word=16'hE4E4; out_ready=1 -> out_valid drops next cycle.
- out_ready=0, three complete frames 16'h1111, 16'h2222, 16'h3333 -> buffer holds 1111/2222, ovf=1 after third; release ready -> 1111 then 2222 read, no 3333.
- In LOCK, in_sig asserted with 4th dibit -> sync_err 1-cycle pulse, no push, following 8-dibit frame packs correctly.
- In LOCK, 8th dibit without in_sig -> sync_err pulse, locked=0, dibits ignored until next in_sig.
- Assert reset after 5 dibits of a frame with one word buffered -> out_valid=0, ovf=0, locked=0, out_word=0 immediately (async).
